// File: rtl/serial_tx_arbiter_if.sv
// serial_tx_arbiter_if
// Bundles every signal between the serial transmit arbiter, its message
// sources and the AVR transmit port.
//   Requester side : req, msg_len (LEN_BITS per requester), msg_data (8 bits
//                    per requester, combinational from rd_addr), grant,
//                    rd_addr, done, abort.
//   AVR side       : tx_data, new_tx_data (one-cycle strobe), tx_busy.
// Modports: master = the arbiter, slave = the sources/AVR environment.
interface serial_tx_arbiter_if #(
  parameter int NREQ      = 3,
  parameter int LEN_BITS  = 7,
  parameter int ADDR_BITS = 6
);
  logic [NREQ-1:0]          req;
  logic [NREQ*LEN_BITS-1:0] msg_len;
  logic [NREQ*8-1:0]        msg_data;
  logic [NREQ-1:0]          grant;
  logic [ADDR_BITS-1:0]     rd_addr;
  logic [NREQ-1:0]          done;
  logic                     abort;
  logic                     tx_busy;
  logic [7:0]               tx_data;
  logic                     new_tx_data;

  modport master (
    input  req, msg_len, msg_data, tx_busy,
    output grant, rd_addr, done, abort, tx_data, new_tx_data
  );

  modport slave (
    output req, msg_len, msg_data, tx_busy,
    input  grant, rd_addr, done, abort, tx_data, new_tx_data
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
// Shares the single AVR serial transmit channel between NREQ message sources.
// One whole message is granted at a time, chosen round-robin; the owner's bytes
// are fetched through the shared rd_addr and strobed out to the AVR.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : serial_tx_arbiter_if master (req/msg_len/msg_data/grant/
//                rd_addr/done/abort/tx_busy/tx_data/new_tx_data)
//   dbg_state  : current FSM state (IDLE=0, SEND=1, HOLD=2, DONE=3)
//
// Handshake: a byte is offered only in SEND while tx_busy is low; the arbiter
// then registers tx_data and pulses new_tx_data for exactly one cycle and
// spends one HOLD cycle so the AVR can raise tx_busy before the next byte is
// considered. A requester holds req level-high until it sees its done bit or
// an abort while it owned the grant.
module serial_tx_arbiter #(
  parameter int NREQ         = 3,
  parameter int MAX_LEN      = 64,
  parameter int LEN_BITS     = $clog2(MAX_LEN) + 1,
  parameter int ADDR_BITS    = $clog2(MAX_LEN),
  parameter int BUSY_TIMEOUT = 50000
) (
  input  logic                clk,
  input  logic                rst,
  serial_tx_arbiter_if.master bus,
  output logic [1:0]          dbg_state
);
  localparam int IDX_BITS = $clog2(NREQ);
  localparam int CNT_BITS = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [IDX_BITS-1:0]  owner_q, owner_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [CNT_BITS-1:0]  busy_cnt_q, busy_cnt_d;
  logic [IDX_BITS-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic                 abort_q, abort_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 new_tx_data_q, new_tx_data_d;

  // Round-robin pick: first set req bit scanning upward from rr_ptr, wrapping.
  logic                 found;
  logic [IDX_BITS-1:0]  win_idx;
  logic [LEN_BITS-1:0]  win_len;
  int                   j;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && bus.req[j]) begin
        found   = 1'b1;
        win_idx = IDX_BITS'(j);
      end
    end
    // Oversized lengths are clamped so rd_addr can never run past MAX_LEN-1.
    win_len = bus.msg_len[int'(win_idx)*LEN_BITS +: LEN_BITS];
    if (win_len > LEN_BITS'(MAX_LEN)) win_len = LEN_BITS'(MAX_LEN);
  end

  logic [7:0]          owner_byte;
  logic [IDX_BITS-1:0] next_ptr;
  logic                last_byte;

  assign owner_byte = bus.msg_data[int'(owner_q)*8 +: 8];
  assign next_ptr   = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + IDX_BITS'(1);
  assign last_byte  = (LEN_BITS'(rd_addr_q) + LEN_BITS'(1)) == len_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    rd_addr_d     = rd_addr_q;
    len_d         = len_q;
    busy_cnt_d    = busy_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    done_d        = '0;
    abort_d       = 1'b0;
    tx_data_d     = tx_data_q;
    new_tx_data_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = NREQ'(1) << win_idx;
          owner_d    = win_idx;
          rd_addr_d  = '0;
          len_d      = win_len;
          busy_cnt_d = '0;
          if (win_len == '0) begin
            // Empty message: go straight to DONE, done is registered with it.
            state_d = DONE;
            done_d  = NREQ'(1) << win_idx;
          end else begin
            state_d = SEND;
          end
        end
      end

      SEND: begin
        if (!bus.tx_busy) begin
          tx_data_d     = owner_byte;
          new_tx_data_d = 1'b1;
          state_d       = HOLD;
        end else if (busy_cnt_q == CNT_BITS'(BUSY_TIMEOUT - 1)) begin
          // AVR stuck busy: drop the message and move priority past the owner.
          abort_d  = 1'b1;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end else begin
          busy_cnt_d = busy_cnt_q + CNT_BITS'(1);
        end
      end

      HOLD: begin
        busy_cnt_d = '0;
        if (last_byte) begin
          state_d = DONE;
          done_d  = grant_q;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_BITS'(1);
          state_d   = SEND;
        end
      end

      DONE: begin
        grant_d  = '0;
        rr_ptr_d = next_ptr;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      rd_addr_q     <= '0;
      len_q         <= '0;
      busy_cnt_q    <= '0;
      rr_ptr_q      <= '0;
      done_q        <= '0;
      abort_q       <= 1'b0;
      tx_data_q     <= 8'h00;
      new_tx_data_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      rd_addr_q     <= rd_addr_d;
      len_q         <= len_d;
      busy_cnt_q    <= busy_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      done_q        <= done_d;
      abort_q       <= abort_d;
      tx_data_q     <= tx_data_d;
      new_tx_data_q <= new_tx_data_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.done        = done_q;
  assign bus.abort       = abort_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.new_tx_data = new_tx_data_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter
// Directed bench for serial_tx_arbiter. dut_a uses the default busy timeout,
// dut_b a short one for the stuck-busy case. Expected events (grant changes,
// bytes, done, abort) are pushed per test; a negedge monitor pops and compares.
module tb_serial_tx_arbiter;
  localparam int NREQ      = 3;
  localparam int MAX_LEN   = 64;
  localparam int LEN_BITS  = 7;
  localparam int ADDR_BITS = 6;
  localparam int W         = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_tx_arbiter_if #(.NREQ(NREQ), .LEN_BITS(LEN_BITS), .ADDR_BITS(ADDR_BITS)) bus_a ();
  serial_tx_arbiter_if #(.NREQ(NREQ), .LEN_BITS(LEN_BITS), .ADDR_BITS(ADDR_BITS)) bus_b ();
  logic [1:0] dbg_a, dbg_b;

  serial_tx_arbiter #(.NREQ(NREQ), .MAX_LEN(MAX_LEN), .LEN_BITS(LEN_BITS),
                      .ADDR_BITS(ADDR_BITS)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.master), .dbg_state(dbg_a));

  serial_tx_arbiter #(.NREQ(NREQ), .MAX_LEN(MAX_LEN), .LEN_BITS(LEN_BITS),
                      .ADDR_BITS(ADDR_BITS), .BUSY_TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.master), .dbg_state(dbg_b));

  // ---------------- requester model ----------------
  logic [7:0] mem [NREQ][MAX_LEN];
  int issued_a [NREQ];
  int completed_a [NREQ];
  int issued_b [NREQ];
  int completed_b [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign bus_a.req[gi]            = (issued_a[gi] != completed_a[gi]);
    assign bus_b.req[gi]            = (issued_b[gi] != completed_b[gi]);
    assign bus_a.msg_data[gi*8 +: 8] = mem[gi][bus_a.rd_addr];
    assign bus_b.msg_data[gi*8 +: 8] = mem[gi][bus_b.rd_addr];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp2_q[$];

  localparam logic [3:0] K_GRANT = 4'd1;
  localparam logic [3:0] K_BYTE  = 4'd2;
  localparam logic [3:0] K_DONE  = 4'd3;
  localparam logic [3:0] K_ABORT = 4'd4;

  function automatic logic [W-1:0] ev(input logic [3:0] kind, input logic [7:0] val);
    return {kind, 4'h0, val};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int which, input logic [W-1:0] e);
    if (which == 0) exp_q.push_back(e);
    else exp2_q.push_back(e);
  endtask

  task automatic push_msg(input int which, input int r, input int len, input logic [7:0] base);
    logic [7:0] oh;
    oh = 8'(1 << r);
    push(which, ev(K_GRANT, oh));
    for (int k = 0; k < len; k++) push(which, ev(K_BYTE, 8'(base + k)));
    push(which, ev(K_DONE, oh));
    push(which, ev(K_GRANT, 8'h00));
  endtask

  task automatic sb_cmp(input int which, input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    checks++;
    if ((which == 0 && exp_q.size() == 0) || (which != 0 && exp2_q.size() == 0)) begin
      failures++;
      $display("FAIL dut%0d_%s actual=0x%0h expected=none", which, name, act);
      return;
    end
    if (which == 0) e = exp_q.pop_front();
    else e = exp2_q.pop_front();
    if (e !== act) begin
      failures++;
      $display("FAIL dut%0d_%s actual=0x%0h expected=0x%0h", which, name, act, e);
    end
  endtask

  task automatic observe(input int which, input logic [2:0] g, input logic [2:0] pg,
                         input logic nt, input logic [7:0] td, input logic [2:0] dn,
                         input logic ab);
    if (g !== pg) sb_cmp(which, "grant", ev(K_GRANT, {5'b0, g}));
    if (nt === 1'b1) sb_cmp(which, "tx_byte", ev(K_BYTE, td));
    if (dn !== 3'b000) sb_cmp(which, "done", ev(K_DONE, {5'b0, dn}));
    if (ab === 1'b1) sb_cmp(which, "abort", ev(K_ABORT, 8'h00));
  endtask

  // ---------------- monitor ----------------
  logic       mon_en = 1'b0;
  logic [2:0] pg_a = 3'b000;
  logic [2:0] pg_b = 3'b000;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        completed_a[i] = issued_a[i];
        completed_b[i] = issued_b[i];
      end
    end
    if (mon_en) begin
      observe(0, bus_a.grant, pg_a, bus_a.new_tx_data, bus_a.tx_data, bus_a.done, bus_a.abort);
      observe(1, bus_b.grant, pg_b, bus_b.new_tx_data, bus_b.tx_data, bus_b.done, bus_b.abort);
      for (int i = 0; i < NREQ; i++) begin
        if (bus_a.done[i] === 1'b1 || (bus_a.abort === 1'b1 && pg_a[i])) completed_a[i]++;
        if (bus_b.done[i] === 1'b1 || (bus_b.abort === 1'b1 && pg_b[i])) completed_b[i]++;
      end
    end
    pg_a = bus_a.grant;
    pg_b = bus_b.grant;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"},       32'(bus_a.grant), 0);
    check({tag, "_rd_addr"},     32'(bus_a.rd_addr), 0);
    check({tag, "_done"},        32'(bus_a.done), 0);
    check({tag, "_abort"},       32'(bus_a.abort), 0);
    check({tag, "_tx_data"},     32'(bus_a.tx_data), 0);
    check({tag, "_new_tx_data"}, 32'(bus_a.new_tx_data), 0);
    check({tag, "_state"},       32'(dbg_a), 0);
  endtask

  task automatic load_msg(input int r, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) mem[r][k] = 8'(base + k);
    bus_a.msg_len[r*LEN_BITS +: LEN_BITS] = LEN_BITS'(len);
    bus_b.msg_len[r*LEN_BITS +: LEN_BITS] = LEN_BITS'(len);
  endtask

  task automatic wait_strobe(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus_a.new_tx_data === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_strobe_seen"}, 32'(ok), 1);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp2_q.size() == 0 &&
          bus_a.grant == 3'b000 && bus_b.grant == 3'b000) break;
    end
    repeat (3) @(negedge clk);
    check({name, "_pending_events"}, 32'(exp_q.size() + exp2_q.size()), 0);
    exp_q.delete();
    exp2_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int r = 0; r < NREQ; r++)
      for (int k = 0; k < MAX_LEN; k++) mem[r][k] = 8'h00;
    bus_a.msg_len = '0;
    bus_b.msg_len = '0;
    bus_a.tx_busy = 1'b0;
    bus_b.tx_busy = 1'b0;

    do_reset();
    check_reset_vals("reset");
    mon_en = 1'b1;

    // Single 4-byte message with cycle-exact strobe/done/grant timing.
    load_msg(0, 4, 8'h41);
    push_msg(0, 0, 4, 8'h41);
    issued_a[0]++;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("t1_strobe_c%0d", k), 32'(bus_a.new_tx_data),
            (k == 2 || k == 4 || k == 6 || k == 8) ? 1 : 0);
      check($sformatf("t1_done_c%0d", k), 32'(bus_a.done), (k == 9) ? 1 : 0);
      if (k == 1) check("t1_grant_on", 32'(bus_a.grant), 1);
      if (k == 10) check("t1_grant_off", 32'(bus_a.grant), 0);
    end
    drain("t1");

    // Two simultaneous requests: requester 0 first after reset.
    do_reset();
    load_msg(0, 2, 8'hA0);
    load_msg(1, 2, 8'hB0);
    push_msg(0, 0, 2, 8'hA0);
    push_msg(0, 1, 2, 8'hB0);
    issued_a[0]++;
    issued_a[1]++;
    drain("t2");

    // Requesters 0 and 2 held for two messages each: grants alternate.
    do_reset();
    load_msg(0, 1, 8'h10);
    load_msg(1, 1, 8'h20);
    load_msg(2, 1, 8'h30);
    push_msg(0, 0, 1, 8'h10);
    push_msg(0, 2, 1, 8'h30);
    push_msg(0, 0, 1, 8'h10);
    push_msg(0, 2, 1, 8'h30);
    issued_a[0] += 2;
    issued_a[2] += 2;
    drain("t3");

    // tx_busy stall of 10 cycles in SEND.
    do_reset();
    load_msg(1, 3, 8'h51);
    push_msg(0, 1, 3, 8'h51);
    issued_a[1]++;
    wait_strobe("t4_first");
    bus_a.tx_busy = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_a.new_tx_data === 1'b1) n++;
    end
    check("t4_stall_strobes", 32'(n), 0);
    bus_a.tx_busy = 1'b0;
    @(negedge clk);
    check("t4_release_strobe", 32'(bus_a.new_tx_data), 1);
    drain("t4");

    // Zero-length message on requester 1.
    do_reset();
    load_msg(1, 0, 8'h00);
    push_msg(0, 1, 0, 8'h00);
    issued_a[1]++;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus_a.new_tx_data === 1'b1) n++;
    end
    check("t5_strobes", 32'(n), 0);
    drain("t5");

    // Stuck tx_busy on dut_b (timeout 8): abort, then requester 1 served.
    do_reset();
    load_msg(0, 2, 8'h70);
    load_msg(1, 2, 8'hC1);
    bus_b.tx_busy = 1'b1;
    push(1, ev(K_GRANT, 8'h01));
    push(1, ev(K_GRANT, 8'h00));
    push(1, ev(K_ABORT, 8'h00));
    push_msg(1, 1, 2, 8'hC1);
    issued_b[0]++;
    issued_b[1]++;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_b.grant != 3'b000) break;
    end
    check("t6_grant0", 32'(bus_b.grant), 1);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n++;
      if (bus_b.abort === 1'b1) break;
    end
    check("t6_abort_latency", 32'(n), 8);
    bus_b.tx_busy = 1'b0;
    drain("t6");

    // Reset after byte 2 of 5, then a fresh request restarts at byte 0.
    do_reset();
    load_msg(0, 5, 8'h61);
    push(0, ev(K_GRANT, 8'h01));
    push(0, ev(K_BYTE, 8'h61));
    push(0, ev(K_BYTE, 8'h62));
    push(0, ev(K_GRANT, 8'h00));
    issued_a[0]++;
    wait_strobe("t7_b1");
    wait_strobe("t7_b2");
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("t7_midreset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_msg(0, 0, 5, 8'h61);
    issued_a[0]++;
    @(negedge clk);
    check("t7_restart_addr", 32'(bus_a.rd_addr), 0);
    drain("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
